// File: rtl/muldiv_pkg.sv
// Shared definitions for the RV32M multiply/divide unit: op encodings, FSM states and
// latency constants.
package muldiv_pkg;

  typedef enum logic [2:0] {
    OpMul    = 3'b000,
    OpMulh   = 3'b001,
    OpMulhsu = 3'b010,
    OpMulhu  = 3'b011,
    OpDiv    = 3'b100,
    OpDivu   = 3'b101,
    OpRem    = 3'b110,
    OpRemu   = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    StIdle,
    StMul,
    StDiv,
    StDone
  } state_e;

  localparam int unsigned DIV_ITERS = 32;
  localparam int unsigned MUL_LAT   = 2;

endpackage

// File: rtl/muldiv_if.sv
// Request/response bundle between the issue stage and the multiply/divide unit.
interface muldiv_if #(
  parameter int unsigned XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      op;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic [4:0]      rd_in;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic [4:0]      rd_out;
  logic            err;

  modport master (
    output in_valid, op, rs1_data, rs2_data, rd_in, flush, out_ready,
    input  in_ready, out_valid, result, rd_out, err
  );

  modport slave (
    input  in_valid, op, rs1_data, rs2_data, rd_in, flush, out_ready,
    output in_ready, out_valid, result, rd_out, err
  );
endinterface

// File: rtl/muldiv_div_iter.sv
// Radix-2 restoring divider on operand magnitudes with a final sign fix-up.
// Pulses done_o one cycle after the last of DIV_ITERS iterations.
module muldiv_div_iter
  import muldiv_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        abort_i,
  input  logic [31:0] dividend_i,
  input  logic [31:0] divisor_i,
  input  logic        signed_i,
  input  logic        rem_i,
  output logic        done_o,
  output logic [31:0] result_o
);

  logic [31:0] rem_q, quo_q, dvs_q, res_q;
  logic [5:0]  cnt_q;
  logic        busy_q, done_q, neg_quo_q, neg_rem_q, rem_sel_q;

  logic [32:0] rem_shift;
  logic        fits;
  logic [31:0] rem_next, quo_next, abs_a, abs_b, fixed;

  always_comb begin
    abs_a     = (signed_i && dividend_i[31]) ? -dividend_i : dividend_i;
    abs_b     = (signed_i && divisor_i[31]) ? -divisor_i : divisor_i;
    rem_shift = {rem_q, quo_q[31]};
    fits      = rem_shift >= {1'b0, dvs_q};
    // When fits is set the difference is below 2^32, so 32-bit subtraction is exact.
    rem_next  = fits ? (rem_shift[31:0] - dvs_q) : rem_shift[31:0];
    quo_next  = {quo_q[30:0], fits};
    if (rem_sel_q) begin
      fixed = neg_rem_q ? -rem_q : rem_q;
    end else begin
      fixed = neg_quo_q ? -quo_q : quo_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      res_q     <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      rem_sel_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (abort_i) begin
        busy_q <= 1'b0;
        cnt_q  <= '0;
      end else if (start_i) begin
        rem_q     <= '0;
        quo_q     <= abs_a;
        dvs_q     <= abs_b;
        cnt_q     <= 6'(DIV_ITERS);
        busy_q    <= 1'b1;
        neg_quo_q <= signed_i && (dividend_i[31] ^ divisor_i[31]);
        neg_rem_q <= signed_i && dividend_i[31];
        rem_sel_q <= rem_i;
      end else if (busy_q) begin
        if (cnt_q != '0) begin
          rem_q <= rem_next;
          quo_q <= quo_next;
          cnt_q <= cnt_q - 6'd1;
        end else begin
          res_q  <= fixed;
          done_q <= 1'b1;
          busy_q <= 1'b0;
        end
      end
    end
  end

  assign done_o   = done_q;
  assign result_o = res_q;

endmodule

// File: rtl/muldiv_unit.sv
// RV32M multiply/divide unit. Division is built only with MULDIV_DIV_EN defined;
// otherwise ops 100-111 return result=0 with err=1 after MUL_LAT cycles.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input logic     clk,
  input logic     rst,
  muldiv_if.slave mdu
);

  state_e          state_q, state_d;
  op_e             op_q;
  logic [XLEN-1:0] a_q, b_q, result_q;
  logic [4:0]      rd_q;
  logic [1:0]      cnt_q;
  logic [63:0]     product_q;
  logic            err_q;

  logic            accept, in_div, in_special, mul_last, a_sgn, b_sgn, mul_err, div_done;
  logic [63:0]     a_ext, b_ext, product;
  logic [XLEN-1:0] mul_res, div_res;

  assign accept   = mdu.in_valid && (state_q == StIdle) && !mdu.flush;
  assign in_div   = mdu.op[2];
  assign mul_last = (cnt_q == 2'(MUL_LAT - 1));

`ifdef MULDIV_DIV_EN
  // Divide-by-zero and signed overflow skip the iterations via the fixed-latency path.
  assign in_special = (mdu.rs2_data == '0) ||
                      (!mdu.op[0] && mdu.rs1_data == {1'b1, {(XLEN-1){1'b0}}} &&
                       mdu.rs2_data == '1);
`else
  assign in_special = 1'b1;
`endif

  assign a_sgn   = (op_q == OpMulh || op_q == OpMulhsu) && a_q[XLEN-1];
  assign b_sgn   = (op_q == OpMulh) && b_q[XLEN-1];
  assign a_ext   = {{(64-XLEN){a_sgn}}, a_q};
  assign b_ext   = {{(64-XLEN){b_sgn}}, b_q};
  assign product = a_ext * b_ext;

  always_comb begin
    mul_res = '0;
    mul_err = 1'b0;
    unique case (op_q)
      OpMul:                     mul_res = product_q[XLEN-1:0];
      OpMulh, OpMulhsu, OpMulhu: mul_res = product_q[2*XLEN-1:XLEN];
      default: begin
`ifdef MULDIV_DIV_EN
        if (b_q == '0) begin
          mul_res = op_q[1] ? a_q : '1;
        end else begin
          mul_res = op_q[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
        end
`else
        mul_err = 1'b1;
`endif
      end
    endcase
  end

`ifdef MULDIV_DIV_EN
  logic div_start;
  assign div_start = accept && in_div && !in_special;

  muldiv_div_iter u_div (
    .clk        (clk),
    .rst        (rst),
    .start_i    (div_start),
    .abort_i    (mdu.flush),
    .dividend_i (mdu.rs1_data),
    .divisor_i  (mdu.rs2_data),
    .signed_i   (!mdu.op[0]),
    .rem_i      (mdu.op[1]),
    .done_o     (div_done),
    .result_o   (div_res)
  );
`else
  assign div_done = 1'b0;
  assign div_res  = '0;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (accept) state_d = (in_div && !in_special) ? StDiv : StMul;
      StMul:  if (mul_last) state_d = StDone;
      StDiv:  if (div_done) state_d = StDone;
      StDone: if (mdu.out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (mdu.flush) state_d = StIdle;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= StIdle;
    else      state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_q      <= OpMul;
      a_q       <= '0;
      b_q       <= '0;
      rd_q      <= '0;
      cnt_q     <= '0;
      product_q <= '0;
      result_q  <= '0;
      err_q     <= 1'b0;
    end else if (accept) begin
      op_q  <= op_e'(mdu.op);
      a_q   <= mdu.rs1_data;
      b_q   <= mdu.rs2_data;
      rd_q  <= mdu.rd_in;
      cnt_q <= '0;
    end else if (!mdu.flush) begin
      if (state_q == StMul) begin
        product_q <= product;
        cnt_q     <= cnt_q + 2'd1;
        if (mul_last) begin
          result_q <= mul_res;
          err_q    <= mul_err;
        end
      end
      if (state_q == StDiv && div_done) begin
        result_q <= div_res;
        err_q    <= 1'b0;
      end
    end
  end

  assign mdu.in_ready  = (state_q == StIdle);
  assign mdu.out_valid = (state_q == StDone);
  assign mdu.result    = result_q;
  assign mdu.rd_out    = rd_q;
  assign mdu.err       = err_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed vectors push expectations, a negedge monitor
// checks latency, stall stability and handoff data.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

`ifdef MULDIV_DIV_EN
  localparam int FlushAt = 10;
`else
  localparam int FlushAt = 1;
`endif

  muldiv_if #(.XLEN(32)) mdu ();

  muldiv_unit #(.XLEN(32)) dut (
    .clk (clk),
    .rst (rst_n),
    .mdu (mdu)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] res;
    int          lat;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    logic        err;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sb[$];

  // Expected values for the divider-enabled build; the default build overrides div ops.
  vec_t vecs [0:17] = '{
    '{OpMul,    32'h0000_0007, 32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, 2},
    '{OpMulhu,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6,  32'hFFFF_FFFE, 2},
    '{OpMulh,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7,  32'h0000_0000, 2},
    '{OpMulhsu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8,  32'hFFFF_FFFF, 2},
    '{OpMul,    32'h1234_5678, 32'h0000_0010, 5'd9,  32'h2345_6780, 2},
    '{OpMulh,   32'h8000_0000, 32'h8000_0000, 5'd10, 32'h4000_0000, 2},
    '{OpDiv,    32'hFFFF_FFEC, 32'h0000_0003, 5'd11, 32'hFFFF_FFFA, 34},
    '{OpRem,    32'hFFFF_FFEC, 32'h0000_0003, 5'd12, 32'hFFFF_FFFE, 34},
    '{OpDivu,   32'h0000_0020, 32'h0000_0000, 5'd13, 32'hFFFF_FFFF, 2},
    '{OpRemu,   32'h0000_0020, 32'h0000_0000, 5'd14, 32'h0000_0020, 2},
    '{OpDiv,    32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'h8000_0000, 2},
    '{OpRem,    32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'h0000_0000, 2},
    '{OpDivu,   32'h0000_0064, 32'h0000_0007, 5'd17, 32'h0000_000E, 34},
    '{OpRemu,   32'h0000_0064, 32'h0000_0007, 5'd18, 32'h0000_0002, 34},
    '{OpDiv,    32'h0000_0014, 32'hFFFF_FFFD, 5'd19, 32'hFFFF_FFFA, 34},
    '{OpRem,    32'h0000_0014, 32'hFFFF_FFFD, 5'd20, 32'h0000_0002, 34},
    '{OpDivu,   32'hFFFF_FFFF, 32'h0000_0001, 5'd21, 32'hFFFF_FFFF, 34},
    '{OpDiv,    32'hFFFF_FFEC, 32'h0000_0000, 5'd22, 32'hFFFF_FFFF, 2}
  };

  vec_t stall_vec = '{OpMulhu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd25, 32'hFFFF_FFFE, 2};
  vec_t flush_vec = '{OpDiv,   32'hFFFF_FFEC, 32'h0000_0003, 5'd26, 32'hFFFF_FFFA, 34};
  vec_t rst_vec   = '{OpDivu,  32'h0000_0064, 32'h0000_0007, 5'd27, 32'h0000_000E, 34};
  vec_t post_vec  = '{OpMul,   32'h0000_0005, 32'h0000_0006, 5'd3,  32'h0000_001E, 2};

  function automatic exp_t model(input vec_t v, input int acc);
    exp_t e;
    e.rd  = v.rd;
    e.acc = acc;
    e.res = v.res;
    e.err = 1'b0;
    e.lat = v.lat;
`ifndef MULDIV_DIV_EN
    if (v.op[2]) begin
      e.res = '0;
      e.err = 1'b1;
      e.lat = MUL_LAT;
    end
`endif
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic issue(input vec_t v, input bit push);
    int n = 0;
    while (!mdu.in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!mdu.in_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL issue_timeout: in_ready got 0 for %0d cycles, expected 1", n);
    end else begin
      mdu.op       = v.op;
      mdu.rs1_data = v.a;
      mdu.rs2_data = v.b;
      mdu.rd_in    = v.rd;
      mdu.in_valid = 1'b1;
      if (push) sb.push_back(model(v, cyc + 1));
      @(negedge clk);
      mdu.in_valid = 1'b0;
    end
  endtask

  logic prev_valid = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid = 1'b0;
    end else begin
      if (mdu.out_valid) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_out_valid: got result %h, expected no output", mdu.result);
        end else begin
          if (!prev_valid) check("latency", 32'(cyc - sb[0].acc), 32'(sb[0].lat));
          check("in_ready_while_valid", {31'b0, mdu.in_ready}, 32'd0);
          if (mdu.out_ready) begin
            check("result", mdu.result, sb[0].res);
            check("rd_out", {27'b0, mdu.rd_out}, {27'b0, sb[0].rd});
            check("err", {31'b0, mdu.err}, {31'b0, sb[0].err});
            void'(sb.pop_front());
          end else begin
            check("stall_result", mdu.result, sb[0].res);
            check("stall_rd_out", {27'b0, mdu.rd_out}, {27'b0, sb[0].rd});
          end
        end
      end
      prev_valid = mdu.out_valid;
    end
  end

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain_pending", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation got no completion, expected $finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1);
  end

  initial begin
    int n;
    int vcount;
    mdu.in_valid  = 1'b0;
    mdu.op        = '0;
    mdu.rs1_data  = '0;
    mdu.rs2_data  = '0;
    mdu.rd_in     = '0;
    mdu.flush     = 1'b0;
    mdu.out_ready = 1'b1;

    repeat (2) @(negedge clk);
    check("rst_out_valid", {31'b0, mdu.out_valid}, 32'd0);
    check("rst_result", mdu.result, 32'd0);
    check("rst_rd_out", {27'b0, mdu.rd_out}, 32'd0);
    check("rst_err", {31'b0, mdu.err}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1 check("in_ready_after_reset", {31'b0, mdu.in_ready}, 32'd1);
    @(negedge clk);

    foreach (vecs[i]) issue(vecs[i], 1'b1);
    drain();

    // Consumer stall: result must hold until the first out_ready=1 cycle.
    mdu.out_ready = 1'b0;
    issue(stall_vec, 1'b1);
    n = 0;
    while (!mdu.out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("stall_valid_seen", {31'b0, mdu.out_valid}, 32'd1);
    repeat (5) @(negedge clk);
    @(posedge clk);
    #1 mdu.out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("handoff_valid_drop", {31'b0, mdu.out_valid}, 32'd0);
    check("handoff_in_ready", {31'b0, mdu.in_ready}, 32'd1);
    drain();

    // Flush mid-operation: no result, back to idle next cycle.
    issue(flush_vec, 1'b0);
    repeat (FlushAt - 1) @(negedge clk);
    mdu.flush = 1'b1;
    @(negedge clk);
    mdu.flush = 1'b0;
    check("flush_in_ready", {31'b0, mdu.in_ready}, 32'd1);
    check("flush_out_valid", {31'b0, mdu.out_valid}, 32'd0);
    vcount = 0;
    repeat (40) begin
      @(negedge clk);
      if (mdu.out_valid) vcount++;
    end
    check("flush_no_result", 32'(vcount), 32'd0);

    // Flush with a simultaneous request: the request is dropped.
    mdu.op       = OpMul;
    mdu.rs1_data = 32'd3;
    mdu.rs2_data = 32'd4;
    mdu.rd_in    = 5'd30;
    mdu.in_valid = 1'b1;
    mdu.flush    = 1'b1;
    @(negedge clk);
    mdu.in_valid = 1'b0;
    mdu.flush    = 1'b0;
    check("flush_req_in_ready", {31'b0, mdu.in_ready}, 32'd1);
    vcount = 0;
    repeat (5) begin
      @(negedge clk);
      if (mdu.out_valid) vcount++;
    end
    check("flush_req_dropped", 32'(vcount), 32'd0);

    // Asynchronous reset mid-operation.
    issue(rst_vec, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_out_valid", {31'b0, mdu.out_valid}, 32'd0);
    check("async_rst_in_ready", {31'b0, mdu.in_ready}, 32'd1);
    check("async_rst_result", mdu.result, 32'd0);
    check("async_rst_rd_out", {27'b0, mdu.rd_out}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1 check("in_ready_after_rerst", {31'b0, mdu.in_ready}, 32'd1);
    @(negedge clk);

    issue(post_vec, 1'b1);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
